// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman controller: FSM state encoding,
// default parameter values and the reserved blank letter code.
package hangman_pkg;

  localparam int DEF_WORD_LEN   = 5;
  localparam int DEF_LETTER_W   = 5;
  localparam int DEF_MAX_MISSES = 7;
  localparam int BLANK_LETTER   = 0;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_WAIT_GUESS = 3'd2,
    S_SCAN       = 3'd3,
    S_UPDATE     = 3'd4,
    S_WON        = 3'd5,
    S_LOST       = 3'd6
  } state_t;

endpackage

// File: rtl/hangman_word_reg.sv
// Secret-word storage with an indexed letter mux and the revealed-letter
// vector; letter i lives in the MSB-first slot and owns found bit WORD_LEN-1-i.
module hangman_word_reg #(
  parameter int WORD_LEN = 5,
  parameter int LETTER_W = 5,
  parameter int IDX_W    = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [WORD_LEN*LETTER_W-1:0] word_in,
  input  logic [IDX_W-1:0]             idx,
  input  logic                         mark,
  output logic [LETTER_W-1:0]          letter,
  output logic [WORD_LEN-1:0]          found
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);

  logic [WORD_LEN*LETTER_W-1:0] word;
  logic [LETTER_W-1:0]          letters [WORD_LEN];
  logic [IDX_W-1:0]             ridx;

  always_comb begin
    for (int i = 0; i < WORD_LEN; i++) begin
      letters[i] = word[(WORD_LEN-1-i)*LETTER_W +: LETTER_W];
    end
  end

  assign letter = letters[idx];
  assign ridx   = LAST_IDX - idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word  <= '0;
      found <= '0;
    end else if (load) begin
      word  <= word_in;
      found <= '0;
    end else if (mark) begin
      found[ridx] <= 1'b1;
    end
  end

endmodule

// File: rtl/hangman_ctrl_p.sv
// Hangman game controller: scans the stored word one letter per cycle for
// each accepted guess, then scores it (hit / miss) and decides won / lost.
module hangman_ctrl_p
  import hangman_pkg::*;
#(
  parameter int WORD_LEN   = DEF_WORD_LEN,
  parameter int LETTER_W   = DEF_LETTER_W,
  parameter int MAX_MISSES = DEF_MAX_MISSES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         new_game,
  input  logic [WORD_LEN*LETTER_W-1:0] word_in,
  input  logic                         guess_valid,
  input  logic [LETTER_W-1:0]          guess_letter,
  output logic [WORD_LEN-1:0]          found,
  output logic [3:0]                   miss_count,
  output logic                         busy,
  output logic                         guess_ack,
  output logic                         game_won,
  output logic                         game_lost,
  output logic [2:0]                   state_dbg
);

  // Handshake: guess_valid is taken only in a cycle where busy is low and the
  // letter is non-blank; nothing is queued. Completion is the one-cycle
  // guess_ack pulse, after which busy is already low for the next guess.

  localparam int               IDX_W    = $clog2(WORD_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     scan_idx;
  logic                 hit;
  logic [LETTER_W-1:0]  guess_reg;
  logic [LETTER_W-1:0]  cur_letter;
  logic [3:0]           miss_next;
  logic                 accept, match, load_word, mark;

  assign accept    = guess_valid && (guess_letter != LETTER_W'(BLANK_LETTER));
  assign match     = (cur_letter == guess_reg);
  assign miss_next = (!hit && (miss_count < 4'(MAX_MISSES))) ? miss_count + 4'd1 : miss_count;

  hangman_word_reg #(
    .WORD_LEN (WORD_LEN),
    .LETTER_W (LETTER_W),
    .IDX_W    (IDX_W)
  ) u_word (
    .clk     (clk),
    .reset   (reset),
    .load    (load_word),
    .word_in (word_in),
    .idx     (scan_idx),
    .mark    (mark),
    .letter  (cur_letter),
    .found   (found)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (new_game) begin
      state_nxt = S_LOAD;
    end else begin
      case (state)
        S_IDLE:       state_nxt = S_IDLE;
        S_LOAD:       state_nxt = S_WAIT_GUESS;
        S_WAIT_GUESS: if (accept) state_nxt = S_SCAN;
        S_SCAN:       if (scan_idx == LAST_IDX) state_nxt = S_UPDATE;
        S_UPDATE: begin
          if (&found)                              state_nxt = S_WON;
          else if (miss_next == 4'(MAX_MISSES))    state_nxt = S_LOST;
          else                                     state_nxt = S_WAIT_GUESS;
        end
        S_WON:        state_nxt = S_WON;
        S_LOST:       state_nxt = S_LOST;
        default:      state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != S_WAIT_GUESS);
    game_won  = (state == S_WON);
    game_lost = (state == S_LOST);
    state_dbg = state;
    load_word = (state == S_LOAD);
    mark      = (state == S_SCAN) && match && !new_game;
  end

  // A pending new_game aborts whatever the datapath was doing, so no ack leaks out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_idx   <= '0;
      hit        <= 1'b0;
      guess_reg  <= '0;
      miss_count <= '0;
      guess_ack  <= 1'b0;
    end else begin
      guess_ack <= 1'b0;
      if (!new_game) begin
        case (state)
          S_LOAD: begin
            scan_idx   <= '0;
            hit        <= 1'b0;
            miss_count <= '0;
          end
          S_WAIT_GUESS: begin
            if (accept) begin
              guess_reg <= guess_letter;
              scan_idx  <= '0;
            end
          end
          S_SCAN: begin
            if (match) hit <= 1'b1;
            scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
          end
          S_UPDATE: begin
            guess_ack  <= 1'b1;
            miss_count <= miss_next;
            hit        <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hangman_ctrl_p.sv
// Bench for hangman_ctrl_p: a 5-letter and a 4-letter instance share stimulus;
// a letter-list game model supplies every expected value.
module tb_hangman_ctrl_p;

  localparam int LW   = 5;
  localparam int MAXM = 7;
  localparam logic [24:0] SPEC_WORD  = 25'b01101_01110_10011_10001_00101;
  localparam logic [19:0] SHORT_WORD = 20'b00101_00101_00010_00101;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_game, guess_valid;
  logic [4:0]  guess_letter;
  logic [24:0] word5;
  logic [19:0] word4;

  logic [4:0]  found5;
  logic [3:0]  miss5;
  logic        busy5, ack5, won5, lost5;
  logic [2:0]  st5;
  logic [3:0]  found4;
  logic [3:0]  miss4;
  logic        busy4, ack4, won4, lost4;
  logic [2:0]  st4;

  int vectors = 0;
  int errors  = 0;
  int sel     = 0;
  int wl      = 5;

  int mw [16];
  bit mrev [16];
  int m_miss;
  bit m_won, m_lost;

  logic [15:0] cur_found;
  logic [3:0]  cur_miss;
  logic        cur_ack, cur_busy, cur_won, cur_lost;

  always #5 clk = ~clk;

  hangman_ctrl_p dut5 (
    .clk(clk), .reset(reset), .new_game(new_game), .word_in(word5),
    .guess_valid(guess_valid), .guess_letter(guess_letter),
    .found(found5), .miss_count(miss5), .busy(busy5), .guess_ack(ack5),
    .game_won(won5), .game_lost(lost5), .state_dbg(st5)
  );

  hangman_ctrl_p #(.WORD_LEN(4)) dut4 (
    .clk(clk), .reset(reset), .new_game(new_game), .word_in(word4),
    .guess_valid(guess_valid), .guess_letter(guess_letter),
    .found(found4), .miss_count(miss4), .busy(busy4), .guess_ack(ack4),
    .game_won(won4), .game_lost(lost4), .state_dbg(st4)
  );

  always_comb begin
    if (sel == 1) begin
      cur_found = {12'd0, found4}; cur_miss = miss4; cur_ack = ack4;
      cur_busy = busy4; cur_won = won4; cur_lost = lost4;
    end else begin
      cur_found = {11'd0, found5}; cur_miss = miss5; cur_ack = ack5;
      cur_busy = busy5; cur_won = won5; cur_lost = lost5;
    end
  end

  function automatic logic [15:0] exp_found();
    logic [15:0] f;
    f = '0;
    for (int i = 0; i < wl; i++) if (mrev[i]) f[wl-1-i] = 1'b1;
    return f;
  endfunction

  function automatic void model_guess(input int letter);
    bit hit;
    hit = 0;
    for (int i = 0; i < wl; i++) begin
      if (mw[i] == letter) begin
        mrev[i] = 1;
        hit = 1;
      end
    end
    if (!hit && m_miss < MAXM) m_miss++;
    m_won = 1;
    for (int i = 0; i < wl; i++) if (!mrev[i]) m_won = 0;
    m_lost = !m_won && (m_miss == MAXM);
  endfunction

  // Called at a falling edge; returns at a falling edge with the DUT in WAIT_GUESS.
  task automatic start_game(input logic [24:0] w5, input logic [19:0] w4);
    logic [24:0] ws;
    new_game = 1'b1; word5 = w5; word4 = w4;
    @(negedge clk);
    new_game = 1'b0;
    @(negedge clk);
    ws = (sel == 1) ? {5'd0, w4} : w5;
    for (int i = 0; i < 16; i++) begin mw[i] = 0; mrev[i] = 0; end
    for (int i = 0; i < wl; i++) begin
      logic [24:0] t;
      t = ws >> ((wl - 1 - i) * LW);
      mw[i] = int'(t[4:0]);
    end
    m_miss = 0; m_won = 0; m_lost = 0;
  endtask

  // lat = rising edges from the accepting edge until guess_ack is seen; -1 on timeout.
  task automatic do_guess(input logic [4:0] letter, output int lat);
    guess_valid = 1'b1; guess_letter = letter;
    @(posedge clk);
    lat = 0;
    forever begin
      @(negedge clk);
      guess_valid = 1'b0;
      if (cur_ack) break;
      if (lat >= 40) begin lat = -1; break; end
      @(posedge clk);
      lat++;
    end
    model_guess(int'(letter));
  endtask

  task automatic test_reset();
    reset = 1'b0; new_game = 1'b0; guess_valid = 1'b0; guess_letter = '0;
    word5 = '0; word4 = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({found5, miss5, ack5, won5, lost5, busy5} !== {5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset5 got %b expected %b", {found5, miss5, ack5, won5, lost5, busy5}, 13'b0000000000001);
    end
    vectors++;
    if ({found4, miss4, ack4, won4, lost4, busy4} !== {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset4 got %b expected %b", {found4, miss4, ack4, won4, lost4, busy4}, 12'b000000000001);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy5 !== 1'b1 || ack5 !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got busy=%b ack=%b expected busy=1 ack=0", busy5, ack5);
    end
  endtask

  task automatic test_spec_word();
    logic [4:0] g [5] = '{5'b01101, 5'b01110, 5'b10011, 5'b10001, 5'b00101};
    logic [4:0] f [5] = '{5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111};
    int lat;
    sel = 0; wl = 5;
    start_game(SPEC_WORD, 20'd0);
    vectors++;
    if (cur_busy !== 1'b0) begin
      errors++; $display("FAIL load_to_wait busy got %b expected 0", cur_busy);
    end
    for (int i = 0; i < 5; i++) begin
      do_guess(g[i], lat);
      vectors++;
      if (lat !== wl + 1) begin
        errors++; $display("FAIL spec_latency[%0d] got %0d expected %0d", i, lat, wl + 1);
      end
      vectors++;
      if (cur_found[4:0] !== f[i] || cur_miss !== 4'd0 || cur_won !== (i == 4) || cur_lost !== 1'b0) begin
        errors++;
        $display("FAIL spec_guess[%0d] got found=%b miss=%0d won=%b lost=%b expected found=%b miss=0 won=%b lost=0",
                 i, cur_found[4:0], cur_miss, cur_won, cur_lost, f[i], (i == 4));
      end
    end
  endtask

  task automatic test_all_miss();
    int lat;
    sel = 0; wl = 5;
    start_game(SPEC_WORD, 20'd0);
    for (int i = 0; i < MAXM; i++) begin
      do_guess(5'b00001, lat);
      vectors++;
      if (lat !== wl + 1 || cur_miss !== 4'(i + 1) || cur_lost !== m_lost || cur_won !== 1'b0) begin
        errors++;
        $display("FAIL miss[%0d] got lat=%0d miss=%0d lost=%b expected lat=%0d miss=%0d lost=%b",
                 i, lat, cur_miss, cur_lost, wl + 1, i + 1, m_lost);
      end
    end
    guess_valid = 1'b1; guess_letter = 5'b01101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (cur_ack !== 1'b0 || cur_miss !== 4'd7 || cur_lost !== 1'b1 || cur_found !== 16'd0) begin
        errors++;
        $display("FAIL lost_hold[%0d] got ack=%b miss=%0d lost=%b found=%h expected ack=0 miss=7 lost=1 found=0",
                 i, cur_ack, cur_miss, cur_lost, cur_found);
      end
    end
    guess_valid = 1'b0;
  endtask

  task automatic test_zero_guess();
    int lat;
    sel = 0; wl = 5;
    start_game(SPEC_WORD, 20'd0);
    guess_valid = 1'b1; guess_letter = 5'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (cur_ack !== 1'b0 || cur_busy !== 1'b0 || cur_found !== 16'd0 || cur_miss !== 4'd0) begin
        errors++;
        $display("FAIL zero_guess[%0d] got ack=%b busy=%b found=%h miss=%0d expected 0 0 0 0",
                 i, cur_ack, cur_busy, cur_found, cur_miss);
      end
    end
    guess_valid = 1'b0;
    do_guess(5'b10001, lat);
    vectors++;
    if (lat !== wl + 1 || cur_found !== exp_found()) begin
      errors++;
      $display("FAIL after_zero got lat=%0d found=%h expected lat=%0d found=%h", lat, cur_found, wl + 1, exp_found());
    end
  endtask

  task automatic test_back_to_back();
    int lat, n;
    logic [24:0] w;
    sel = 0; wl = 5;
    for (int game = 0; game < 4; game++) begin
      w = '0;
      for (int i = 0; i < 5; i++) w = {w[19:0], 5'($urandom_range(1, 6))};
      start_game(w, 20'd0);
      n = 0;
      while (!m_won && !m_lost && n < 40) begin
        do_guess(5'($urandom_range(1, 8)), lat);
        n++;
        vectors++;
        if (lat !== wl + 1 || cur_found !== exp_found() || cur_miss !== 4'(m_miss) ||
            cur_won !== m_won || cur_lost !== m_lost || cur_busy !== (m_won || m_lost)) begin
          errors++;
          $display("FAIL rand g%0d n%0d got lat=%0d found=%h miss=%0d won=%b lost=%b busy=%b expected lat=%0d found=%h miss=%0d won=%b lost=%b busy=%b",
                   game, n, lat, cur_found, cur_miss, cur_won, cur_lost, cur_busy,
                   wl + 1, exp_found(), m_miss, m_won, m_lost, (m_won || m_lost));
        end
      end
    end
  endtask

  task automatic test_abort_scan();
    int lat;
    sel = 0; wl = 5;
    start_game(SPEC_WORD, 20'd0);
    do_guess(5'b00001, lat);
    do_guess(5'b01101, lat);
    guess_valid = 1'b1; guess_letter = 5'b01110;
    @(posedge clk);
    @(negedge clk);
    guess_valid = 1'b0;
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    vectors++;
    if (cur_ack !== 1'b0 || cur_busy !== 1'b1) begin
      errors++; $display("FAIL abort_load got ack=%b busy=%b expected ack=0 busy=1", cur_ack, cur_busy);
    end
    new_game = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (cur_ack !== 1'b0 || cur_found !== 16'd0 || cur_miss !== 4'd0 || cur_busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_wait[%0d] got ack=%b found=%h miss=%0d busy=%b expected 0 0 0 0",
                 i, cur_ack, cur_found, cur_miss, cur_busy);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    sel = 0; wl = 5;
    start_game(SPEC_WORD, 20'd0);
    do_guess(5'b00001, lat);
    do_guess(5'b01101, lat);
    guess_valid = 1'b1; guess_letter = 5'b01110;
    @(posedge clk);
    @(negedge clk);
    guess_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({found5, miss5, ack5, won5, lost5, busy5} !== {5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_scan got %b expected %b", {found5, miss5, ack5, won5, lost5, busy5}, 13'b0000000000001);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (cur_ack !== 1'b0 || cur_busy !== 1'b1 || cur_found !== 16'd0) begin
        errors++;
        $display("FAIL post_reset_idle[%0d] got ack=%b busy=%b found=%h expected 0 1 0", i, cur_ack, cur_busy, cur_found);
      end
    end
  endtask

  task automatic test_short_word();
    int lat;
    sel = 1; wl = 4;
    start_game(SPEC_WORD, SHORT_WORD);
    do_guess(5'b00101, lat);
    vectors++;
    if (lat !== 5 || cur_found[3:0] !== 4'b1101 || cur_found !== exp_found() || cur_miss !== 4'd0) begin
      errors++;
      $display("FAIL short_first got lat=%0d found=%b miss=%0d expected lat=5 found=1101 miss=0", lat, cur_found[3:0], cur_miss);
    end
    do_guess(5'b00101, lat);
    vectors++;
    if (lat !== 5 || cur_found[3:0] !== 4'b1101 || cur_miss !== 4'd0 || cur_won !== 1'b0) begin
      errors++;
      $display("FAIL short_repeat got lat=%0d found=%b miss=%0d won=%b expected lat=5 found=1101 miss=0 won=0",
               lat, cur_found[3:0], cur_miss, cur_won);
    end
    do_guess(5'b00010, lat);
    vectors++;
    if (cur_found[3:0] !== 4'b1111 || cur_won !== m_won || cur_won !== 1'b1) begin
      errors++;
      $display("FAIL short_win got found=%b won=%b expected found=1111 won=1", cur_found[3:0], cur_won);
    end
    sel = 0; wl = 5;
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_spec_word();
    test_all_miss();
    test_zero_guess();
    test_back_to_back();
    test_abort_scan();
    test_reset_mid_scan();
    test_short_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hangman_ctrl_p.md
HANGMAN_CTRL_P -- requirements
Module: hangman_ctrl_p

Interface
REQ-001 Parameter WORD_LEN, default 5, number of letters per word (2..16).
REQ-002 Parameter LETTER_W, default 5, bits per letter code; code 0 reserved as blank/invalid.
REQ-003 Parameter MAX_MISSES, default 7, wrong guesses that end the game (1..15).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 new_game  in  1  level-sampled; 1 at an edge starts a new game.
REQ-007 word_in  in  WORD_LEN*LETTER_W  secret word, letter 0 in MSBs; sampled only in LOAD.
REQ-008 guess_valid  in  1  guess strobe, sampled in WAIT_GUESS only.
REQ-009 guess_letter  in  LETTER_W  guessed letter code.
REQ-010 found  out  WORD_LEN  bit WORD_LEN-1-i set when letter i is revealed.
REQ-011 miss_count  out  4  wrong guesses so far.
REQ-012 busy  out  1  high in every state except WAIT_GUESS.
REQ-013 guess_ack  out  1  one-cycle pulse when a guess finishes scoring.
REQ-014 game_won / game_lost  out  1 each  level, high in WON / LOST respectively.

Function
REQ-015 FSM states: IDLE, LOAD, WAIT_GUESS, SCAN, UPDATE, WON, LOST.
REQ-016 IDLE: on new_game=1 go to LOAD; else stay.
REQ-017 LOAD: capture word_in, clear found, miss_count, hit flag and scan index; next state WAIT_GUESS.
REQ-018 WAIT_GUESS: on guess_valid=1 with guess_letter!=0, latch letter and go to SCAN with index 0; guess_letter=0 is ignored, no ack.
REQ-019 SCAN: compare one letter per cycle, index 0 to WORD_LEN-1; on match set its found bit and the hit flag; all occurrences revealed; after index WORD_LEN-1 go to UPDATE.
REQ-020 A guess matching an already-found letter counts as a hit; found bits never clear outside LOAD/reset.
REQ-021 UPDATE: pulse guess_ack; if no hit, miss_count increments by 1; clear hit flag.
REQ-022 UPDATE transitions: all found bits set -> WON; else updated miss_count == MAX_MISSES -> LOST; else WAIT_GUESS.
REQ-023 Guess latency: guess_valid edge to guess_ack high = WORD_LEN+1 cycles; next guess accepted the cycle after ack.
REQ-024 guess_valid outside WAIT_GUESS is ignored and not queued.
REQ-025 WON/LOST hold found and miss_count until new_game=1, then go to LOAD.
REQ-026 new_game=1 in any state goes to LOAD next cycle, aborting any scan with no ack; priority over guess_valid.
REQ-027 miss_count saturates at MAX_MISSES; never wraps.

Reset
REQ-028 Reset low forces IDLE immediately; found=0, miss_count=0, guess_ack=0, game_won=0, game_lost=0, busy=1, stored word=0.
REQ-029 Reset asserted mid-scan discards the guess; deassertion resumes from IDLE only.

Structure
REQ-030 Package hangman_pkg holds state enum, default parameter values and the blank-letter constant.
REQ-031 Sub-module hangman_word_reg holds word storage, indexed-letter mux and found vector; FSM and miss counter stay in top.

Verification
REQ-032 Defaults, word 01101_01110_10011_10001_00101, guess 01101 -> ack 6 cycles later, found=10000, miss_count=0.
REQ-033 Same word, guesses 01110,10011,10001,00101 in order -> found 11000,11100,11110,11111, game_won=1 after last ack.
REQ-034 Same word, seven guesses of 00001 -> miss_count 1..7, game_lost=1 after 7th ack; further guess_valid ignored.
REQ-035 WORD_LEN=4, word 00101_00101_00010_00101, guess 00101 -> found=1101 in one guess; repeat guess -> miss_count stays 0.
REQ-036 new_game asserted during SCAN -> no guess_ack, LOAD next cycle, found=0, miss_count=0.
REQ-037 Reset pulled low during SCAN -> outputs at reset values same cycle; guess_letter=0 in WAIT_GUESS -> no ack, state unchanged.
